// File: rtl/atm_ledger_arbiter_pkg.sv
// Shared definitions for the ATM ledger arbiter: op codes, response status codes,
// FSM state encoding and the step used to preload the ledger on reset.
package atm_ledger_arbiter_pkg;

    localparam logic [1:0] OP_BALANCE  = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd1;
    localparam logic [2:0] ST_OVERFLOW     = 3'd2;
    localparam logic [2:0] ST_BAD_ACC      = 3'd3;
    localparam logic [2:0] ST_BAD_OP       = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam int LEDGER_STEP = 1000;

endpackage

// File: rtl/atm_ledger_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or above ptr,
// wrapping around, and returns it both one-hot and as a binary index.
module atm_ledger_arbiter_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Serializes ATM terminal transactions onto one shared balance ledger: round-robin
// grant in IDLE, atomic read-modify-write in EXEC, one-cycle response pulse afterwards.
module atm_ledger_arbiter #(
    parameter int N_TERM = 4,
    parameter int N_ACC  = 10,
    parameter int IDX_W  = 4,
    parameter int BAL_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TERM-1:0]         req_valid,
    input  logic [2*N_TERM-1:0]       req_op,
    input  logic [IDX_W*N_TERM-1:0]   req_acc,
    input  logic [BAL_W*N_TERM-1:0]   req_amount,
    output logic [N_TERM-1:0]         req_ready,
    output logic                      rsp_valid,
    output logic [2:0]                rsp_term,
    output logic [2:0]                rsp_status,
    output logic [BAL_W-1:0]          rsp_balance,
    output logic                      busy
);

    import atm_ledger_arbiter_pkg::*;

    localparam int PTR_W = $clog2(N_TERM);

    state_t             state, next_state;
    logic [PTR_W-1:0]   rr_ptr, win_idx, lat_term;
    logic [N_TERM-1:0]  grant;
    logic [1:0]         lat_op;
    logic [IDX_W-1:0]   lat_acc;
    logic [BAL_W-1:0]   lat_amt;
    logic [BAL_W-1:0]   ledger [N_ACC];

    logic               acc_ok;
    logic [BAL_W-1:0]   cur_bal, new_bal;
    logic [BAL_W:0]     sum;
    logic [2:0]         res_status;
    logic               do_write;

    atm_ledger_arbiter_rr_arbiter #(
        .N     (N_TERM),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = grant;
                if (|req_valid) next_state = S_EXEC;
            end
            S_EXEC: begin
                busy       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Account range is checked first so an out-of-range index never reaches the ledger.
    assign acc_ok  = {1'b0, lat_acc} < (IDX_W+1)'(N_ACC);
    assign cur_bal = acc_ok ? ledger[lat_acc] : '0;
    assign sum     = {1'b0, cur_bal} + {1'b0, lat_amt};

    always_comb begin
        res_status = ST_OK;
        new_bal    = cur_bal;
        do_write   = 1'b0;
        if (!acc_ok) begin
            res_status = ST_BAD_ACC;
        end else begin
            case (lat_op)
                OP_BALANCE: ;
                OP_WITHDRAW: begin
                    if (lat_amt <= cur_bal) begin
                        new_bal  = cur_bal - lat_amt;
                        do_write = 1'b1;
                    end else begin
                        res_status = ST_INSUFFICIENT;
                    end
                end
                OP_DEPOSIT: begin
                    if (sum[BAL_W]) begin
                        res_status = ST_OVERFLOW;
                    end else begin
                        new_bal  = sum[BAL_W-1:0];
                        do_write = 1'b1;
                    end
                end
                OP_RESERVED: res_status = ST_BAD_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            lat_term    <= '0;
            lat_op      <= '0;
            lat_acc     <= '0;
            lat_amt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_term    <= '0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            for (int i = 0; i < N_ACC; i++) ledger[i] <= BAL_W'(LEDGER_STEP * (i + 1));
        end else begin
            rsp_valid <= 1'b0;
            if (state == S_IDLE && |req_valid) begin
                lat_term <= win_idx;
                lat_op   <= req_op[win_idx*2 +: 2];
                lat_acc  <= req_acc[win_idx*IDX_W +: IDX_W];
                lat_amt  <= req_amount[win_idx*BAL_W +: BAL_W];
                rr_ptr   <= (win_idx == PTR_W'(N_TERM-1)) ? '0 : win_idx + 1'b1;
            end
            if (state == S_EXEC) begin
                if (do_write) ledger[lat_acc] <= new_bal;
                rsp_valid   <= 1'b1;
                rsp_term    <= 3'(lat_term);
                rsp_status  <= res_status;
                rsp_balance <= new_bal;
            end
        end
    end

endmodule
